// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter/rotator: coarse STEP-bit moves, then single-bit moves, with a start/busy/done handshake.
// Optional abort input is compiled in when SEQ_SHIFT_ABORT_EN is defined.
module seq_shift_unit #(
  parameter int WIDTH = 64,
  parameter int STEP  = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
`ifdef SEQ_SHIFT_ABORT_EN
  input  logic             abort,
`endif
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);
  localparam logic [AMT_W-1:0] ONE_A  = AMT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] step_amt;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] v,
                                                   input logic [1:0]       m,
                                                   input logic [AMT_W-1:0] d);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    case (m)
      2'b00:   shift_word = v << d;
      2'b01:   shift_word = v >> d;
      2'b10:   shift_word = sv >>> d;
      default: shift_word = (v << d) | (v >> (WIDTH - int'(d)));
    endcase
  endfunction

  // Coarse moves while at least STEP remains, then single-bit moves finish the distance.
  assign step_amt = (rem_q >= STEP_A) ? STEP_A : ONE_A;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          q_d     = data;
          mode_d  = mode;
          rem_d   = amount;
          state_d = (amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
`ifdef SEQ_SHIFT_ABORT_EN
        if (abort) begin
          state_d = IDLE;
          rem_d   = '0;
        end else begin
`else
        begin
`endif
          q_d   = shift_word(q_q, mode_q, step_amt);
          rem_d = rem_q - step_amt;
          if (rem_d == '0) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      mode_q  <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit (WIDTH=64, STEP=8) with hand-computed results.
module tb_seq_shift_unit;

  localparam int WIDTH = 64;
  localparam int STEP  = 8;
  localparam int AMT_W = 6;

  logic             clk = 1'b0;
  logic             resetn;
  logic             start;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
`ifdef SEQ_SHIFT_ABORT_EN
  logic             abort;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  seq_shift_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
`ifdef SEQ_SHIFT_ABORT_EN
    .abort  (abort),
`endif
    .mode   (mode),
    .amount (amount),
    .data   (data),
    .q      (q),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to its done pulse; mid>0 pulses a stray start on that busy cycle.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [AMT_W-1:0] amt,
                        input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_q,
                        input int exp_busy, input int mid);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 0;
    @(negedge clk);
    start = 1'b1; mode = m; amount = amt; data = d;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_load"}, q, d);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1;
      else if (busy) begin
        cnt++;
        if (cnt == mid) begin
          start = 1'b1; mode = 2'b00; amount = 6'd5; data = 64'hDEAD_BEEF_0BAD_F00D;
        end
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'(exp_busy));
    chk({tag, "_result"}, q, exp_q);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    chk({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_hold"}, q, exp_q);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; mode = 2'b00; amount = '0; data = '0;
`ifdef SEQ_SHIFT_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_q", q, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    resetn = 1'b1;

    run_op("lsl17", 2'b00, 6'd17, 64'h1, 64'h0000_0000_0002_0000, 3, 0);
    run_op("asr12", 2'b10, 6'd12, 64'h8000_0000_0000_0000, 64'hFFF8_0000_0000_0000, 5, 0);
    run_op("rol4",  2'b11, 6'd4,  64'hF000_0000_0000_0001, 64'h0000_0000_0000_001F, 4, 0);
    run_op("lsr9",  2'b01, 6'd9,  64'h8000_0000_0000_0000, 64'h0040_0000_0000_0000, 2, 0);
    run_op("asrpos", 2'b10, 6'd2, 64'h4000_0000_0000_0000, 64'h1000_0000_0000_0000, 2, 0);
    run_op("rol63", 2'b11, 6'd63, 64'h1, 64'h8000_0000_0000_0000, 14, 0);
    run_op("lsl63", 2'b00, 6'd63, 64'h1, 64'h8000_0000_0000_0000, 14, 0);
    run_op("zero",  2'b01, 6'd0,  64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0, 0);
    run_op("ignst", 2'b01, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 14, 5);

    // Start held high: accepted again straight out of DONE.
    @(negedge clk);
    start = 1'b1; mode = 2'b00; amount = 6'd1; data = 64'h3;
    @(posedge clk); #1;
    chk("b2b_load1", q, 64'h3);
    @(posedge clk); #1;
    chk("b2b_done1", {62'd0, done, busy}, 64'b10);
    chk("b2b_res1", q, 64'h6);
    @(posedge clk); #1;
    chk("b2b_load2", {62'd0, done, busy}, 64'b01);
    chk("b2b_q2", q, 64'h3);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done2", {62'd0, done, busy}, 64'b10);
    @(posedge clk); #1;
    chk("b2b_idle", {62'd0, done, busy}, 64'b00);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    start = 1'b1; mode = 2'b00; amount = 6'd63; data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("mrst_busy_before", {63'd0, busy}, 64'd1);
    resetn = 1'b0;
    #1;
    chk("mrst_q", q, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("postrst", 2'b00, 6'd8, 64'h1, 64'h100, 1, 0);

`ifdef SEQ_SHIFT_ABORT_EN
    @(negedge clk);
    start = 1'b1; mode = 2'b01; amount = 6'd20; data = 64'hFF00_0000_0000_0000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abt_step1", q, 64'h00FF_0000_0000_0000);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    chk("abt_q", q, 64'h00FF_0000_0000_0000);
    chk("abt_flags", {62'd0, done, busy}, 64'b00);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abt_no_done", {62'd0, done, busy}, 64'b00);
    end
    chk("abt_hold", q, 64'h00FF_0000_0000_0000);
    run_op("postabt", 2'b11, 6'd1, 64'h8000_0000_0000_0000, 64'h1, 1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
